// File: rtl/ysyx_23060124_issue_ctrl_pkg.sv
// Shared definitions for the in-order issue controller: FSM encoding and
// default sizing of the scoreboard and in-flight window.
package ysyx_23060124_issue_ctrl_pkg;

  localparam int NR_REG_DEF       = 16;
  localparam int CNT_W_DEF        = 2;
  localparam int MAX_INFLIGHT_DEF = 4;
  localparam int INF_W_DEF        = 3;

  // RUN issues; DRAIN holds a serial instruction until older ones retire;
  // WAIT holds everything younger than a serial/control instruction.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WAIT  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/ysyx_23060124_scoreboard.sv
// Per-register pending-write counters. Entry 0 is hard-wired to zero.
// A simultaneous increment and decrement on the same entry cancel out; a
// decrement of an empty entry is suppressed and flagged as underflow.
module ysyx_23060124_scoreboard
  import ysyx_23060124_issue_ctrl_pkg::*;
#(
  parameter int NR_REG = NR_REG_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int IDX_W  = $clog2(NR_REG)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic             dec_en,
  input  logic [IDX_W-1:0] dec_idx,
  input  logic [IDX_W-1:0] rd_idx1,
  input  logic [IDX_W-1:0] rd_idx2,
  input  logic [IDX_W-1:0] rd_idx3,
  output logic             busy1,
  output logic             busy2,
  output logic             sat3,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt [NR_REG];
  logic [NR_REG-1:0] inc_hit;
  logic [NR_REG-1:0] dec_hit;

  assign busy1     = (rd_idx1 != '0) && (cnt[rd_idx1] != '0);
  assign busy2     = (rd_idx2 != '0) && (cnt[rd_idx2] != '0);
  assign sat3      = (rd_idx3 != '0) && (cnt[rd_idx3] == CNT_MAX);
  assign underflow = dec_en && (dec_idx != '0) && (cnt[dec_idx] == '0);

  // Decode which entry is incremented/decremented this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 1; i < NR_REG; i++) begin
      inc_hit[i] = inc_en && (inc_idx == IDX_W'(i));
      dec_hit[i] = dec_en && (dec_idx == IDX_W'(i)) && (cnt[i] != '0);
    end
  end

  // Counter array update; entry 0 never leaves zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is architectural state that must read as "no pending writes" after reset, so it is reset explicitly rather than left to a RAM.
      for (int i = 0; i < NR_REG; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NR_REG; i++) begin
        // NOTE: state updates use non-blocking assignments so every entry sees pre-edge values.
        if (inc_hit[i] && !dec_hit[i])      cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec_hit[i] && !inc_hit[i]) cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ysyx_23060124_issue_ctrl.sv
// In-order issue controller between decode and EXU. Holds an instruction
// until its sources have no pending writes, bounds the in-flight window and
// serialises CSR/system and control-flow instructions.
module ysyx_23060124_issue_ctrl
  import ysyx_23060124_issue_ctrl_pkg::*;
#(
  parameter int NR_REG       = NR_REG_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int INF_W        = INF_W_DEF,
  parameter int IDX_W        = $clog2(NR_REG)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] id_rs1,
  input  logic [IDX_W-1:0] id_rs2,
  input  logic [IDX_W-1:0] id_rd,
  input  logic             id_wen,
  input  logic             id_serial,
  input  logic             id_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             wb_valid,
  input  logic             wb_wen,
  input  logic [IDX_W-1:0] wb_rd,
  output logic             busy,
  output logic             stall_raw,
  output logic             err
);

  issue_state_e     state, state_next;
  logic [INF_W-1:0] inflight, inflight_next;
  logic             err_q;

  logic sb_busy1, sb_busy2, sb_sat3, sb_underflow;
  logic raw, waw_full, full, inflight_zero;
  logic issue, wb_ok, err_set;

  ysyx_23060124_scoreboard #(
    .NR_REG (NR_REG),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .inc_en    (issue && id_wen),
    .inc_idx   (id_rd),
    .dec_en    (wb_valid && wb_wen),
    .dec_idx   (wb_rd),
    .rd_idx1   (id_rs1),
    .rd_idx2   (id_rs2),
    .rd_idx3   (id_rd),
    .busy1     (sb_busy1),
    .busy2     (sb_busy2),
    .sat3      (sb_sat3),
    .underflow (sb_underflow)
  );

  assign raw           = sb_busy1 || sb_busy2;
  assign waw_full      = id_wen && sb_sat3;
  assign full          = (inflight == INF_W'(MAX_INFLIGHT));
  assign inflight_zero = (inflight == '0);

  assign out_valid = in_valid && !raw && !waw_full && !full &&
                     (state == ST_RUN) && (!id_serial || inflight_zero);
  assign issue     = out_valid && out_ready;
  assign in_ready  = issue;
  assign stall_raw = in_valid && raw;
  assign busy      = !inflight_zero;
  assign err       = err_q;

  // A writeback with nothing in flight is a protocol error and is ignored.
  assign wb_ok   = wb_valid && !inflight_zero;
  assign err_set = (wb_valid && inflight_zero) || sb_underflow;

  // Next in-flight count; issue and retire in the same cycle cancel.
  always_comb begin
    inflight_next = inflight;
    case ({issue, wb_ok})
      2'b10:   inflight_next = inflight + INF_W'(1);
      2'b01:   inflight_next = inflight - INF_W'(1);
      default: inflight_next = inflight;
    endcase
  end

  // Next-state logic for the serialisation FSM.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (issue && (id_serial || id_ctrl))              state_next = ST_WAIT;
        else if (in_valid && id_serial && !inflight_zero) state_next = ST_DRAIN;
      end
      ST_DRAIN, ST_WAIT: begin
        if (inflight_next == '0) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // State, in-flight counter and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= inflight_next;
      err_q    <= err_q || err_set;
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_issue_ctrl.sv
// Self-checking bench for the issue controller. A reference model tracks the
// in-flight instructions as a queue; each driven cycle pushes the expected
// outputs, and a monitor pops and compares them on the falling edge.
module tb_ysyx_23060124_issue_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid, in_ready;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       id_wen, id_serial, id_ctrl;
  logic       out_valid, out_ready;
  logic       wb_valid, wb_wen;
  logic [3:0] wb_rd;
  logic       busy, stall_raw, err;

  ysyx_23060124_issue_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rd     (id_rd),
    .id_wen    (id_wen),
    .id_serial (id_serial),
    .id_ctrl   (id_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_valid  (wb_valid),
    .wb_wen    (wb_wen),
    .wb_rd     (wb_rd),
    .busy      (busy),
    .stall_raw (stall_raw),
    .err       (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic ov;
    logic ir;
    logic sr;
    logic bz;
    logic er;
  } obs_t;

  typedef struct {
    logic [3:0] rd;
    logic       wen;
    logic       barrier;
  } instr_t;

  obs_t   exp_q[$];
  instr_t flight[$];
  logic   m_err   = 1'b0;
  logic   m_drain = 1'b0;
  logic   last_issue;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Outstanding writes to register r among in-flight instructions.
  function automatic int pend(input logic [3:0] r);
    int n = 0;
    if (r == 4'd0) return 0;
    for (int k = 0; k < flight.size(); k++)
      if (flight[k].wen && flight[k].rd == r) n++;
    return n;
  endfunction

  // A serial or control instruction is in flight: nothing younger may issue.
  function automatic logic barrier_present();
    for (int k = 0; k < flight.size(); k++)
      if (flight[k].barrier) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    logic hz, waw, full, run, ov;
    hz   = (pend(id_rs1) != 0) || (pend(id_rs2) != 0);
    waw  = id_wen && (pend(id_rd) == 3);
    full = (flight.size() == 4);
    run  = !m_drain && !barrier_present();
    ov   = in_valid && !hz && !waw && !full && run && (!id_serial || flight.size() == 0);
    o.ov = ov;
    o.ir = ov && out_ready;
    o.sr = in_valid && hz;
    o.bz = (flight.size() != 0);
    o.er = m_err;
    return o;
  endfunction

  task automatic model_clear();
    flight.delete();
    m_err   = 1'b0;
    m_drain = 1'b0;
  endtask

  // Advance the model across a rising edge using the inputs held over it.
  task automatic model_edge(input logic issue);
    logic enter;
    if (!reset) return;
    if (wb_valid && (flight.size() == 0 || (wb_wen && wb_rd != 4'd0 && pend(wb_rd) == 0)))
      m_err = 1'b1;
    enter = !m_drain && !barrier_present() && in_valid && id_serial && flight.size() != 0;
    if (wb_valid && flight.size() != 0) void'(flight.pop_front());
    if (issue) flight.push_back('{rd: id_rd, wen: id_wen, barrier: id_serial || id_ctrl});
    if (m_drain) m_drain = (flight.size() != 0);
    else         m_drain = enter;
  endtask

  // One clock cycle with the current inputs.
  task automatic cycle();
    obs_t e;
    if (!reset) model_clear();
    e = model_obs();
    exp_q.push_back(e);
    last_issue = e.ov && out_ready;
    @(posedge clock);
    model_edge(last_issue);
    #1;
  endtask

  // Monitor: compare DUT outputs against the queued expectation.
  initial begin
    obs_t e, got;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = '{out_valid, in_ready, stall_raw, busy, err};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs {ov,ir,sr,busy,err}: got %b expected %b at %0t", got, e, $time);
        end
      end
    end
  end

  task automatic no_wb();
    wb_valid = 1'b0;
    wb_wen   = 1'b0;
    wb_rd    = 4'd0;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    id_rs1    = 4'd0;
    id_rs2    = 4'd0;
    id_rd     = 4'd0;
    id_wen    = 1'b0;
    id_serial = 1'b0;
    id_ctrl   = 1'b0;
    out_ready = 1'b1;
    no_wb();
  endtask

  task automatic present(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic wen, input logic serial, input logic ctrl);
    in_valid  = 1'b1;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    id_wen    = wen;
    id_serial = serial;
    id_ctrl   = ctrl;
  endtask

  // Retire the oldest in-flight instruction (in-order EXU).
  task automatic wb_front();
    if (flight.size() != 0) begin
      wb_valid = 1'b1;
      wb_wen   = flight[0].wen;
      wb_rd    = flight[0].rd;
    end else begin
      no_wb();
    end
  endtask

  task automatic drain_all();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && flight.size() != 0; k++) begin
      wb_front();
      cycle();
    end
    no_wb();
    #1;
    check("drain_idle", busy, 1'b0);
  endtask

  task automatic random_phase(input int n);
    logic have = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        have = 1'b1;
        present(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
      end
      in_valid  = have;
      out_ready = ($urandom_range(0, 9) < 8);
      if (flight.size() != 0 && $urandom_range(0, 9) < 4) wb_front();
      else no_wb();
      cycle();
      if (last_issue) have = 1'b0;
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    cycle();
    reset = 1'b1;
    cycle();

    // RAW stall and no same-cycle bypass through the scoreboard.
    present(4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
    #1 check("t1_first_issue", out_valid, 1'b1);
    cycle();
    present(4'd5, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0);
    #1 check("t1_stall_raw", stall_raw, 1'b1);
    check("t1_held", out_valid, 1'b0);
    cycle();
    wb_front();
    #1 check("t1_no_bypass", out_valid, 1'b0);
    cycle();
    no_wb();
    #1 check("t1_after_wb", out_valid, 1'b1);
    cycle();
    idle();
    drain_all();

    // In-flight saturation.
    for (int k = 0; k < 4; k++) begin
      present(4'd0, 4'd0, 4'(7 + k), 1'b1, 1'b0, 1'b0);
      cycle();
    end
    present(4'd0, 4'd0, 4'd12, 1'b1, 1'b0, 1'b0);
    #1 check("t2_full", out_valid, 1'b0);
    cycle();
    wb_front();
    #1 check("t2_full_wb_cycle", out_valid, 1'b0);
    cycle();
    no_wb();
    #1 check("t2_after_wb", out_valid, 1'b1);
    cycle();
    idle();
    drain_all();

    // Per-register counter saturation holds a fourth writer.
    for (int k = 0; k < 3; k++) begin
      present(4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    present(4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
    #1 check("waw_full", out_valid, 1'b0);
    cycle();
    idle();
    drain_all();

    // Serial drain then wait.
    present(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    cycle();
    present(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    cycle();
    present(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    #1 check("t3_serial_held", out_valid, 1'b0);
    cycle();
    wb_front();
    cycle();
    wb_front();
    cycle();
    no_wb();
    #1 check("t3_serial_issue", out_valid, 1'b1);
    cycle();
    present(4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    #1 check("t3_younger_held", out_valid, 1'b0);
    cycle();
    wb_front();
    #1 check("t3_younger_wb_cycle", out_valid, 1'b0);
    cycle();
    no_wb();
    #1 check("t3_younger_issue", out_valid, 1'b1);
    cycle();
    idle();
    drain_all();

    // Control flow waits for its own retirement.
    present(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1);
    cycle();
    present(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    #1 check("t4_held", out_valid, 1'b0);
    cycle();
    wb_front();
    cycle();
    no_wb();
    #1 check("t4_issue", out_valid, 1'b1);
    cycle();
    idle();
    drain_all();

    // Same-cycle issue and writeback on x3; x0 destination never stalls.
    present(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    cycle();
    present(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    wb_front();
    #1 check("t5_issue_with_wb", in_ready, 1'b1);
    cycle();
    no_wb();
    present(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
    #1 check("t5_cnt_kept", stall_raw, 1'b1);
    check("t5_inflight_kept", busy, 1'b1);
    cycle();
    idle();
    drain_all();
    present(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    present(4'd0, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0);
    #1 check("t5_x0_no_stall", stall_raw, 1'b0);
    check("t5_x0_issue", out_valid, 1'b1);
    cycle();
    idle();
    drain_all();

    // Randomized traffic against the model.
    random_phase(2000);
    drain_all();

    // Protocol error is sticky; reset clears everything at once.
    idle();
    wb_valid = 1'b1;
    cycle();
    no_wb();
    #1 check("t6_err_set", err, 1'b1);
    cycle();
    cycle();
    check("t6_err_sticky", err, 1'b1);
    random_phase(200);
    present(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    cycle();
    reset = 1'b0;
    #1 check("t6_rst_err", err, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    cycle();
    reset = 1'b1;
    idle();
    cycle();
    random_phase(300);
    drain_all();

    @(negedge clock);
    #1 check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
